// File: rtl/sm_divider_if.sv
// sm_divider_if: start/operand/result bundle between a requester and the divider
interface sm_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dvf;
  modport master (output start, a, b, input busy, done, q, r, dvf);
  modport slave  (input start, a, b, output busy, done, q, r, dvf);
endinterface

// File: rtl/sm_divider.sv
// sm_divider: sequential sign-magnitude restoring divider, one quotient bit per clock
module sm_divider #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  sm_divider_if.slave bus
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t           state_q, state_d;
  logic [M-1:0]     quo_q, div_q;
  logic [M:0]       par_q;
  logic             sa_q, sb_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic             dvf_q;
  logic             zero_div;
  logic [M:0]       p_sh;
  logic [M+1:0]     trial;
  // Shifted partial remainder, E-carry trial subtraction and next state
  always_comb begin
    zero_div = bus.b[M-1:0] == '0;
    p_sh     = {par_q[M-1:0], quo_q[M-1]};
    trial    = {1'b0, p_sh} + {1'b0, ~{1'b0, div_q}} + (M+2)'(1);
    state_d  = state_q == IDLE ? (bus.start ? (zero_div ? DONE : DIV) : IDLE) :
               state_q == DIV  ? (cnt_q == '0 ? DONE : DIV) : IDLE;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // Operand capture, one restoring step per DIV cycle, result write on the final DIV cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      div_q <= '0;
      par_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dvf_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      if (zero_div) begin
        q_q   <= '0;
        r_q   <= '0;
        dvf_q <= 1'b1;
      end else begin
        quo_q <= bus.a[M-1:0];
        div_q <= bus.b[M-1:0];
        sa_q  <= bus.a[M];
        sb_q  <= bus.b[M];
        par_q <= '0;
        cnt_q <= CW'(M);
        dvf_q <= 1'b0;
      end
    end else if (state_q == DIV) begin
      if (cnt_q == '0) begin
        q_q <= {(sa_q ^ sb_q) & (|quo_q), quo_q};
        r_q <= {sa_q & (|par_q[M-1:0]), par_q[M-1:0]};
      end else begin
        par_q <= trial[M+1] ? trial[M:0] : p_sh;
        quo_q <= {quo_q[M-2:0], trial[M+1]};
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.dvf  = dvf_q;
endmodule
